cpu_memory: RTL
===============

Name: cpu_memory

Overview:
- Pipeline stage downstream of the execute stage. It consumes that stage's tagged output bundle: tag, rd index, result/store data, next pc and memory request fields.
- Loads: performs the bus read and sign/zero-extends the selected lane.
- Stores: performs the bus write, using read-modify-write for sub-word stores.
- Non-memory operations pass straight through to writeback.
- Uses the same tag handshake as the rest of the pipeline: new work is present when i_tag != o_tag.

Parameters:
- none; tag width is `TAG_SIZE from CPU_Defines.v.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  downstream stall; no new work is accepted while high
- i_tag  in  `TAG_SIZE  tag of the presented operation
- i_inst_rd  in  5  destination register index
- i_rd  in  32  ALU/jump result; for stores, the store data
- i_pc_next  in  32  next pc from execute
- i_mem_read  in  1  load request
- i_mem_write  in  1  store request
- i_mem_width  in  3  access width: 1=byte, 2=half, 4=word
- i_mem_signed  in  1  sign-extend load
- i_mem_address  in  32  byte address
- o_tag  out  `TAG_SIZE  tag of the last completed operation
- o_inst_rd  out  5  destination index
- o_rd  out  32  writeback value
- o_pc_next  out  32  forwarded next pc
- o_fault  out  1  last completed op was misaligned or had an illegal width
- o_stall  out  1  busy with a new tag
- o_bus_request  out  1  bus transaction active
- o_bus_rw  out  1  0=read, 1=write
- o_bus_address  out  32  word-aligned address
- o_bus_wdata  out  32  write data
- i_bus_ready  in  1  transaction complete; read data valid this cycle
- i_bus_rdata  in  32  read data

Behaviour:
- Reset:
  - All outputs go to 0 and state goes to IDLE on the next edge.
  - A reset mid-transaction abandons the transaction; o_bus_request is low after that edge.
- States: IDLE, READ, RMW_READ, WRITE.
- Accept condition: state==IDLE && !i_stall && i_tag != o_tag.
  - On accept, all inputs are latched; later input changes are ignored until completion.
- Completion, in every case:
  - o_tag <= latched tag, o_inst_rd <= latched index, o_pc_next <= latched pc_next.
  - State returns to IDLE in the same edge.
- Non-memory op (read=0, write=0): o_rd <= i_rd; completes on the accept edge (1-cycle latency).
- Fault check at accept:
  - Fault conditions: half with addr[0]=1; word with addr[1:0]!=0; width not in {1,2,4}.
  - Response: no bus access, o_rd <= 0, o_fault <= 1, complete on the accept edge.
  - o_fault is reloaded at every completion.
- Load: accept -> READ.
  - o_bus_request=1, o_bus_rw=0, o_bus_address={addr[31:2],2'b00}, held stable until i_bus_ready.
  - On the i_bus_ready edge: extract the lane (little-endian), extend per i_mem_signed into o_rd, complete, drop request.
  - Byte lane = rdata[8*addr[1:0] +: 8]; half lane = rdata[16*addr[1] +: 16].
- Word store: accept -> WRITE with o_bus_wdata=i_rd.
  - On i_bus_ready: complete; o_rd <= i_rd (passed through, not written back by convention).
- Sub-word store: accept -> RMW_READ (read of the aligned word).
  - On i_bus_ready: merge the low byte/half of i_rd into the selected lane of rdata, go to WRITE.
  - o_bus_request drops for exactly one cycle between the read and the write.
- o_stall = (i_tag != o_tag) && state != IDLE.
- i_bus_ready while o_bus_request=0 is ignored.
- i_bus_ready asserted in the first request cycle is legal; minimum load latency is 2 edges.
- i_stall rising while state != IDLE does not pause the bus transaction; it only blocks the next accept.

Decomposition:
- CPU_Defines.v holds:
  - width encodings `MEM_WIDTH_BYTE/HALF/WORD
  - state encodings
- One combinational sub-module, cpu_memory_lane:
  - inputs: address[1:0], width, signed, rdata, wdata
  - outputs: extended load value; merged store word

Test Plan:
- Pass-through: tag 0->1, read=write=0, i_rd=0x1234 -> next edge o_rd=0x1234, o_tag=1, no bus request.
- Signed byte load at 0x1003, rdata=0x80FF_FF00, ready after 3 cycles -> o_rd=0xFFFF_FF80; o_stall high until completion; bus address 0x1000.
- Unsigned half load at 0x2002, rdata=0xBEEF_0000 -> o_rd=0x0000_BEEF.
- Byte store 0xAB at 0x3001, RMW read returns 0x1122_3344 -> write data 0x1122_AB44 to 0x3000, one idle cycle between read and write.
- Misaligned word load at 0x4002 -> no bus request, o_fault=1, o_rd=0, completes in 1 cycle; next legal op clears o_fault.
- Reset asserted while in READ -> o_bus_request=0 after the edge, all outputs 0; a late i_bus_ready is ignored.

Source files
------------

// File: rtl/cpu_memory_pkg.sv
// Shared types and constants for the memory stage: tag width, access-width
// encodings, FSM states and the alignment check.
package cpu_memory_pkg;

    localparam int unsigned TagSize = 4;

    localparam logic [2:0] MemWidthByte = 3'd1;
    localparam logic [2:0] MemWidthHalf = 3'd2;
    localparam logic [2:0] MemWidthWord = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StRmwRead,
        StWrite
    } mem_state_e;

    // Misaligned half/word, or any width outside {1,2,4}.
    function automatic logic access_fault(input logic [2:0] width, input logic [1:0] addr);
        case (width)
            MemWidthByte: access_fault = 1'b0;
            MemWidthHalf: access_fault = addr[0];
            MemWidthWord: access_fault = |addr;
            default:      access_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cpu_memory_lane.sv
// Little-endian lane logic: extracts and extends a load lane, and merges
// sub-word store data into a previously read word.
module cpu_memory_lane
    import cpu_memory_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  width_i,
    input  logic        signed_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
    assign half_lane = rdata_i[{addr_i[1], 4'b0000} +: 16];

    always_comb begin
        load_o = rdata_i;
        case (width_i)
            MemWidthByte: load_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            MemWidthHalf: load_o = {{16{signed_i & half_lane[15]}}, half_lane};
            default:      load_o = rdata_i;
        endcase
    end

    always_comb begin
        store_o = rdata_i;
        case (width_i)
            MemWidthByte: store_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
            MemWidthHalf: store_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default:      store_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/cpu_memory.sv
// Memory pipeline stage: accepts tagged work from execute, performs loads,
// word stores and read-modify-write sub-word stores, and forwards results.
module cpu_memory
    import cpu_memory_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic [TagSize-1:0] i_tag,
    input  logic [4:0]         i_inst_rd,
    input  logic [31:0]        i_rd,
    input  logic [31:0]        i_pc_next,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [2:0]         i_mem_width,
    input  logic               i_mem_signed,
    input  logic [31:0]        i_mem_address,
    output logic [TagSize-1:0] o_tag,
    output logic [4:0]         o_inst_rd,
    output logic [31:0]        o_rd,
    output logic [31:0]        o_pc_next,
    output logic               o_fault,
    output logic               o_stall,
    output logic               o_bus_request,
    output logic               o_bus_rw,
    output logic [31:0]        o_bus_address,
    output logic [31:0]        o_bus_wdata,
    input  logic               i_bus_ready,
    input  logic [31:0]        i_bus_rdata
);

    mem_state_e         state_q;
    logic [TagSize-1:0] tag_q, out_tag_q;
    logic [4:0]         inst_rd_q, out_inst_rd_q;
    logic [31:0]        rd_q, out_rd_q;
    logic [31:0]        pc_next_q, out_pc_next_q;
    logic [31:0]        addr_q, bus_wdata_q;
    logic [2:0]         width_q;
    logic               signed_q, fault_q, bus_request_q, bus_rw_q;
    logic [31:0]        load_value, store_word;
    logic               accept;

    assign accept = (state_q == StIdle) && !i_stall && (i_tag != out_tag_q);

    cpu_memory_lane u_lane (
        .addr_i   (addr_q[1:0]),
        .width_i  (width_q),
        .signed_i (signed_q),
        .rdata_i  (i_bus_rdata),
        .wdata_i  (rd_q),
        .load_o   (load_value),
        .store_o  (store_word)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= StIdle;
            tag_q         <= '0;
            inst_rd_q     <= '0;
            rd_q          <= '0;
            pc_next_q     <= '0;
            addr_q        <= '0;
            width_q       <= '0;
            signed_q      <= 1'b0;
            bus_wdata_q   <= '0;
            bus_request_q <= 1'b0;
            bus_rw_q      <= 1'b0;
            out_tag_q     <= '0;
            out_inst_rd_q <= '0;
            out_rd_q      <= '0;
            out_pc_next_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tag_q     <= i_tag;
                        inst_rd_q <= i_inst_rd;
                        rd_q      <= i_rd;
                        pc_next_q <= i_pc_next;
                        addr_q    <= i_mem_address;
                        width_q   <= i_mem_width;
                        signed_q  <= i_mem_signed;
                        if (!i_mem_read && !i_mem_write) begin
                            out_tag_q     <= i_tag;
                            out_inst_rd_q <= i_inst_rd;
                            out_pc_next_q <= i_pc_next;
                            out_rd_q      <= i_rd;
                            fault_q       <= 1'b0;
                        end else if (access_fault(i_mem_width, i_mem_address[1:0])) begin
                            out_tag_q     <= i_tag;
                            out_inst_rd_q <= i_inst_rd;
                            out_pc_next_q <= i_pc_next;
                            out_rd_q      <= '0;
                            fault_q       <= 1'b1;
                        end else if (i_mem_read) begin
                            state_q       <= StRead;
                            bus_request_q <= 1'b1;
                            bus_rw_q      <= 1'b0;
                        end else if (i_mem_width == MemWidthWord) begin
                            state_q       <= StWrite;
                            bus_request_q <= 1'b1;
                            bus_rw_q      <= 1'b1;
                            bus_wdata_q   <= i_rd;
                        end else begin
                            state_q       <= StRmwRead;
                            bus_request_q <= 1'b1;
                            bus_rw_q      <= 1'b0;
                        end
                    end
                end
                StRead: begin
                    if (i_bus_ready) begin
                        state_q       <= StIdle;
                        bus_request_q <= 1'b0;
                        out_tag_q     <= tag_q;
                        out_inst_rd_q <= inst_rd_q;
                        out_pc_next_q <= pc_next_q;
                        out_rd_q      <= load_value;
                        fault_q       <= 1'b0;
                    end
                end
                StRmwRead: begin
                    // Request drops for one cycle before the write is issued.
                    if (i_bus_ready) begin
                        state_q       <= StWrite;
                        bus_request_q <= 1'b0;
                        bus_rw_q      <= 1'b1;
                        bus_wdata_q   <= store_word;
                    end
                end
                StWrite: begin
                    if (!bus_request_q) begin
                        bus_request_q <= 1'b1;
                    end else if (i_bus_ready) begin
                        state_q       <= StIdle;
                        bus_request_q <= 1'b0;
                        bus_rw_q      <= 1'b0;
                        out_tag_q     <= tag_q;
                        out_inst_rd_q <= inst_rd_q;
                        out_pc_next_q <= pc_next_q;
                        out_rd_q      <= rd_q;
                        fault_q       <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_tag         = out_tag_q;
    assign o_inst_rd     = out_inst_rd_q;
    assign o_rd          = out_rd_q;
    assign o_pc_next     = out_pc_next_q;
    assign o_fault       = fault_q;
    assign o_stall       = (i_tag != out_tag_q) && (state_q != StIdle);
    assign o_bus_request = bus_request_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = {addr_q[31:2], 2'b00};
    assign o_bus_wdata   = bus_wdata_q;

endmodule
